mux_pipe_stage_32bit: RTL and testbench

MUX_PIPE_STAGE_32BIT -- requirements
Module: mux_pipe_stage_32bit

---
 rtl/mux_pipe_stage_32bit.sv | 110 +++++++++++
 tb/tb_mux_pipe_stage_32bit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_stage_32bit.sv
// 2:1 mux into a registered output with a 2-entry skid buffer.
// Ports: clk, rst (sync, high), in0/in1/sel/in_valid/in_ready upstream,
//   out/out_sel/out_valid/out_ready downstream; out_parity when
//   MUX_PIPE_STAGE_PARITY_EN is defined.
module mux_pipe_stage_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_sel,
  output logic             out_valid,
`ifdef MUX_PIPE_STAGE_PARITY_EN
  output logic             out_parity,
`endif
  input  logic             out_ready
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] skid;
  logic [WIDTH-1:0] skid_d;
  logic             skid_sel;
  logic             skid_sel_d;
  logic [WIDTH-1:0] out_d;
  logic             out_sel_d;
  logic [WIDTH-1:0] chosen;
  logic             accept;
  logic             pop;

  assign chosen = sel ? in1 : in0;
  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d    = state;
    out_d      = out;
    out_sel_d  = out_sel;
    skid_d     = skid;
    skid_sel_d = skid_sel;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_d   = BUSY;
          out_d     = chosen;
          out_sel_d = sel;
        end
      end
      BUSY: begin
        if (accept && pop) begin
          out_d     = chosen;
          out_sel_d = sel;
        end else if (accept) begin
          state_d    = FULL;
          skid_d     = chosen;
          skid_sel_d = sel;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can happen
        if (pop) begin
          state_d   = BUSY;
          out_d     = skid;
          out_sel_d = skid_sel;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out       <= '0;
      out_sel   <= 1'b0;
      out_valid <= 1'b0;
      skid      <= '0;
      skid_sel  <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_d;
      out       <= out_d;
      out_sel   <= out_sel_d;
      out_valid <= (state_d != EMPTY);
      skid      <= skid_d;
      skid_sel  <= skid_sel_d;
      // registered ready: no combinational path from out_ready
      in_ready  <= (state_d != FULL);
    end
  end

`ifdef MUX_PIPE_STAGE_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) out_parity <= 1'b0;
    else     out_parity <= ^out_d;
  end
`endif

endmodule

// File: tb/tb_mux_pipe_stage_32bit.sv
// Directed and randomized checks for mux_pipe_stage_32bit.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mux_pipe_stage_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out;
  logic        out_sel;
  logic        out_valid;
  logic        out_ready;
`ifdef MUX_PIPE_STAGE_PARITY_EN
  logic        out_parity;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  mux_pipe_stage_32bit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0       (in0),
    .in1       (in1),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_sel   (out_sel),
    .out_valid (out_valid),
`ifdef MUX_PIPE_STAGE_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    sel      = s;
    in0      = a;
    in1      = b;
  endtask

  logic [32:0] q[$];
  int          cnt;
  logic        acc;
  logic        pp;
  logic [31:0] a;
  logic [31:0] b;
  logic        s;

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    offer(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_out", out, 32'h0);
    chk("rst_sel", {31'b0, out_sel}, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_ready", {31'b0, in_ready}, 32'h0);

    rst = 1'b0;
    tick();
    chk("rel_ready", {31'b0, in_ready}, 32'h1);
    chk("rel_valid", {31'b0, out_valid}, 32'h0);

    // basic select, latency 1
    out_ready = 1'b1;
    offer(1'b1, 1'b1, 32'h0000_1111, 32'hAAAA_5555);
    tick();
    chk("lat_out", out, 32'hAAAA_5555);
    chk("lat_sel", {31'b0, out_sel}, 32'h1);
    chk("lat_valid", {31'b0, out_valid}, 32'h1);
    offer(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0);
    tick();
    chk("empty_valid", {31'b0, out_valid}, 32'h0);
    chk("empty_hold", out, 32'hAAAA_5555);

    // back-pressure into FULL, then drain in order
    out_ready = 1'b0;
    offer(1'b1, 1'b0, 32'h1, 32'hFFFF_FFFF);
    tick();
    chk("bp_out1", out, 32'h1);
    chk("bp_rdy1", {31'b0, in_ready}, 32'h1);
    offer(1'b1, 1'b0, 32'h2, 32'hFFFF_FFFF);
    tick();
    chk("bp_out2", out, 32'h1);
    chk("bp_full", {31'b0, in_ready}, 32'h0);
    offer(1'b1, 1'b0, 32'h3, 32'hFFFF_FFFF);
    tick();
    chk("bp_hold", out, 32'h1);
    chk("bp_noacc", {31'b0, in_ready}, 32'h0);
    out_ready = 1'b1;
    tick();
    chk("dr_out2", out, 32'h2);
    chk("dr_rdy", {31'b0, in_ready}, 32'h1);
    tick();
    chk("dr_out3", out, 32'h3);
    chk("dr_v3", {31'b0, out_valid}, 32'h1);
    offer(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("dr_empty", {31'b0, out_valid}, 32'h0);

    // full throughput with sel toggling
    for (int i = 0; i < 100; i++) begin
      offer(1'b1, i[0], 32'h1000 + i, ~(32'h1000 + i));
      tick();
      chk("tp_out", out, i[0] ? ~(32'h1000 + i) : 32'h1000 + i);
      chk("tp_sel", {31'b0, out_sel}, {31'b0, i[0]});
      chk("tp_valid", {31'b0, out_valid}, 32'h1);
      chk("tp_ready", {31'b0, in_ready}, 32'h1);
    end
    offer(1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // reset while FULL, with a word still offered
    out_ready = 1'b0;
    offer(1'b1, 1'b1, 32'h0, 32'h5A5A_0001);
    tick();
    offer(1'b1, 1'b1, 32'h0, 32'h5A5A_0002);
    tick();
    chk("rf_full", {31'b0, in_ready}, 32'h0);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("rf_out", out, 32'h0);
    chk("rf_valid", {31'b0, out_valid}, 32'h0);
    chk("rf_ready", {31'b0, in_ready}, 32'h0);
    chk("rf_sel", {31'b0, out_sel}, 32'h0);
    rst = 1'b0;
    offer(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("rf_rel_rdy", {31'b0, in_ready}, 32'h1);
    chk("rf_rel_v", {31'b0, out_valid}, 32'h0);
    tick();
    chk("rf_stale", {31'b0, out_valid}, 32'h0);

`ifdef MUX_PIPE_STAGE_PARITY_EN
    offer(1'b1, 1'b0, 32'h7, 32'h0);
    tick();
    chk("par_7", {31'b0, out_parity}, 32'h1);
    offer(1'b1, 1'b0, 32'h3, 32'h0);
    tick();
    chk("par_3", {31'b0, out_parity}, 32'h0);
    offer(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
`endif

    // random handshakes against a queue model
    cnt = 0;
    for (int c = 0; c < 10000; c++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(1));
      offer(1'($urandom_range(1)), s, a, b);
      out_ready = 1'($urandom_range(1));
      chk("rnd_ready", {31'b0, in_ready}, {31'b0, cnt != 2});
      chk("rnd_valid", {31'b0, out_valid}, {31'b0, cnt != 0});
      if (cnt != 0) begin
        chk("rnd_out", out, q[0][31:0]);
        chk("rnd_sel", {31'b0, out_sel}, {31'b0, q[0][32]});
      end
      acc = in_valid && (cnt != 2);
      pp  = out_ready && (cnt != 0);
      if (pp) begin
        void'(q.pop_front());
        cnt--;
      end
      if (acc) begin
        q.push_back({s, s ? b : a});
        cnt++;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
